// File: rtl/drive_arbiter.sv
// Arbitrates the shared vehicle command register between the manual, semi-auto and
// auto controllers, enforcing a stop window on power-up and mode changes, and feeds frames to the UART.
module drive_arbiter #(
    parameter int         STOP_CYCLES = 16,
    parameter logic [3:0] FRAME_TAG   = 4'b1000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [1:0] global_state,
    input  logic [1:0] man_state,
    input  logic [3:0] man_moving,
    input  logic [1:0] semi_state,
    input  logic [3:0] semi_moving,
    input  logic [1:0] auto_state,
    input  logic [3:0] auto_moving,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic [1:0] owner,
    output logic       switching,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    // state | meaning
    // OFF   | engine unpowered, command forced to zero
    // STOP  | stop window after power-up or mode change, command zero
    // RUN   | command follows the controller selected by owner
    typedef enum logic [1:0] {OFF, STOP, RUN} fsm_t;

    localparam int            CW     = $clog2(STOP_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(STOP_CYCLES - 1);

    fsm_t          fsm;
    logic [CW-1:0] cnt;
    logic [3:0]    last_sent;
    logic [1:0]    src_state;
    logic [3:0]    src_moving;

    // Reserved owner 2'b11 selects nothing, so the command stays zero.
    always_comb begin
        src_state  = 2'b00;
        src_moving = 4'b0000;
        case (owner)
            2'b00:   begin src_state = man_state;  src_moving = man_moving;  end
            2'b10:   begin src_state = semi_state; src_moving = semi_moving; end
            2'b01:   begin src_state = auto_state; src_moving = auto_moving; end
            default: begin src_state = 2'b00;      src_moving = 4'b0000;     end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            fsm          <= OFF;
            state        <= 2'b00;
            moving_state <= 4'b0000;
            owner        <= 2'b00;
            switching    <= 1'b0;
            cnt          <= '0;
        end else begin
            case (fsm)
                OFF: begin
                    state        <= 2'b00;
                    moving_state <= 4'b0000;
                    switching    <= 1'b0;
                    if (power) begin
                        fsm       <= STOP;
                        owner     <= global_state;
                        cnt       <= RELOAD;
                        switching <= 1'b1;
                    end
                end
                STOP: begin
                    state        <= 2'b00;
                    moving_state <= 4'b0000;
                    if (!power) begin
                        fsm       <= OFF;
                        switching <= 1'b0;
                    end else if (global_state != owner) begin
                        owner <= global_state;
                        cnt   <= RELOAD;
                    end else if (cnt == '0 && owner != 2'b11) begin
                        fsm       <= RUN;
                        switching <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (!power) begin
                        fsm          <= OFF;
                        state        <= 2'b00;
                        moving_state <= 4'b0000;
                    end else if (global_state != owner) begin
                        fsm          <= STOP;
                        owner        <= global_state;
                        cnt          <= RELOAD;
                        switching    <= 1'b1;
                        state        <= 2'b00;
                        moving_state <= 4'b0000;
                    end else begin
                        state        <= src_state;
                        moving_state <= src_moving;
                    end
                end
                default: fsm <= OFF;
            endcase
        end
    end

    // A pending frame is never withdrawn; updates during it coalesce into the next compare.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tx_valid  <= 1'b0;
            tx_data   <= {FRAME_TAG, 4'b0000};
            last_sent <= 4'b0000;
        end else if (tx_valid && tx_ready) begin
            tx_valid  <= 1'b0;
            last_sent <= tx_data[3:0];
        end else if (!tx_valid && moving_state != last_sent) begin
            tx_valid <= 1'b1;
            tx_data  <= {FRAME_TAG, moving_state};
        end
    end

endmodule
